// File: rtl/mem_port_arbiter_4.sv
// Round-robin arbiter/sequencer sharing one single-ported memory among four requesters.
// One memory transaction per grant; a watchdog releases the port if memory never answers.
`ifndef WORD_LENGTH
`define WORD_LENGTH 32
`endif

module mem_port_arbiter_4 #(
  parameter int TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3:0]              req,
  input  logic                    mem_ready,
  input  logic [`WORD_LENGTH-1:0] mem_rdata,
  output logic [1:0]              sel,
  output logic [3:0]              grant,
  output logic                    mem_start,
  output logic [3:0]              done,
  output logic                    timeout,
  output logic [`WORD_LENGTH-1:0] rdata
);

  localparam int NUM_REQ = 4;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t     state;
  logic [1:0] ptr;
  logic [7:0] wcnt;
  logic [1:0] win;
  logic       win_found;

  // First requester at or after ptr, wrapping modulo 4.
  always_comb begin
    win       = ptr;
    win_found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_found && req[ptr + 2'(i)]) begin
        win       = ptr + 2'(i);
        win_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      sel       <= 2'd0;
      grant     <= 4'd0;
      mem_start <= 1'b0;
      done      <= 4'd0;
      timeout   <= 1'b0;
      rdata     <= '0;
      wcnt      <= 8'd0;
    end else begin
      mem_start <= 1'b0;
      done      <= 4'd0;
      timeout   <= 1'b0;
      case (state)
        IDLE: begin
          if (win_found) begin
            sel       <= win;
            grant     <= 4'b0001 << win;
            mem_start <= 1'b1;
            wcnt      <= 8'd0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          // A completion in the watchdog's final cycle still counts as a completion.
          if (mem_ready) begin
            rdata <= mem_rdata;
            done  <= grant;
            grant <= 4'd0;
            ptr   <= sel + 2'd1;
            state <= IDLE;
          end else if (wcnt == 8'(TIMEOUT - 1)) begin
            timeout <= 1'b1;
            grant   <= 4'd0;
            ptr     <= sel + 2'd1;
            state   <= IDLE;
          end else begin
            wcnt <= wcnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter_4.sv
// Directed bench for mem_port_arbiter_4: reset, single requester, round-robin, skip,
// watchdog, zero-wait memory, ready/timeout collision and dropped request.
`ifndef WORD_LENGTH
`define WORD_LENGTH 32
`endif

module tb_mem_port_arbiter_4;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [3:0]              req;
  logic                    mem_ready;
  logic [`WORD_LENGTH-1:0] mem_rdata;
  logic [1:0]              sel;
  logic [3:0]              grant;
  logic                    mem_start;
  logic [3:0]              done;
  logic                    timeout;
  logic [`WORD_LENGTH-1:0] rdata;

  int npass = 0;
  int ntot  = 0;

  mem_port_arbiter_4 #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .req(req), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .sel(sel), .grant(grant), .mem_start(mem_start), .done(done),
    .timeout(timeout), .rdata(rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] rr_exp [5];

  initial begin
    rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
    rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;
    rst = 1'b1; req = 4'd0; mem_ready = 1'b0; mem_rdata = '0;
    #2;
    chk("rst_sel", 32'(sel), 0);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_start", 32'(mem_start), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_tmo", 32'(timeout), 0);
    chk("rst_rdata", rdata, 0);
    step();
    rst = 1'b0;

    // Async reset while in WAIT with grant=0100
    req = 4'b0100;
    step();
    chk("g2_grant", 32'(grant), 32'b0100);
    chk("g2_sel", 32'(sel), 2);
    chk("g2_start", 32'(mem_start), 1);
    step();
    chk("g2_start_off", 32'(mem_start), 0);
    rst = 1'b1;
    #1;
    chk("midrst_grant", 32'(grant), 0);
    chk("midrst_sel", 32'(sel), 0);
    rst = 1'b0;
    req = 4'b0010;
    step();
    chk("postrst_sel", 32'(sel), 1);
    chk("postrst_grant", 32'(grant), 32'b0010);
    mem_ready = 1'b1; mem_rdata = 32'h1111_2222;
    step();
    chk("postrst_done", 32'(done), 32'b0010);
    mem_ready = 1'b0; req = 4'd0;
    step();

    // Single requester, memory answers 3 cycles after mem_start (ptr=2)
    req = 4'b1000;
    step();
    chk("s_grant", 32'(grant), 32'b1000);
    chk("s_start", 32'(mem_start), 1);
    step();
    chk("s_start_pulse", 32'(mem_start), 0);
    step();
    mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
    step();
    chk("s_done", 32'(done), 32'b1000);
    chk("s_rdata", rdata, 32'hDEADBEEF);
    chk("s_grant_off", 32'(grant), 0);
    mem_ready = 1'b0; mem_rdata = 32'h0; req = 4'd0;
    step();
    chk("s_done_pulse", 32'(done), 0);
    chk("s_sel_hold", 32'(sel), 3);
    chk("s_rdata_hold", rdata, 32'hDEADBEEF);

    // Round-robin with all four requesting (ptr=0)
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rr_grant", 32'(grant), 32'(rr_exp[i]));
      mem_ready = 1'b1; mem_rdata = 32'(i + 100);
      step();
      chk("rr_done", 32'(done), 32'(rr_exp[i]));
      chk("rr_idle", 32'(grant), 0);
      mem_ready = 1'b0;
    end

    // Skip: last winner 0, req=1001 -> 3 then 0
    req = 4'b1001;
    step();
    chk("skip_g3", 32'(grant), 32'b1000);
    mem_ready = 1'b1; mem_rdata = 32'hA5A5_0003;
    step();
    mem_ready = 1'b0;
    step();
    chk("skip_g0", 32'(grant), 32'b0001);
    mem_ready = 1'b1; mem_rdata = 32'hA5A5_0000;
    step();
    chk("skip_rdata", rdata, 32'hA5A5_0000);
    mem_ready = 1'b0; req = 4'd0;
    step();

    // Watchdog: no answer, release on the 16th WAIT cycle (ptr=1 -> winner 0)
    req = 4'b0001; mem_rdata = 32'hBAD0_BAD0;
    step();
    chk("to_grant", 32'(grant), 32'b0001);
    for (int i = 0; i < 15; i++) step();
    chk("to_early", 32'(timeout), 0);
    chk("to_still_granted", 32'(grant), 32'b0001);
    step();
    chk("to_pulse", 32'(timeout), 1);
    chk("to_done", 32'(done), 0);
    chk("to_rdata", rdata, 32'hA5A5_0000);
    chk("to_grant_off", 32'(grant), 0);

    // Next requester wins; memory answers in the mem_start cycle
    req = 4'b0011;
    step();
    chk("to_pulse_clr", 32'(timeout), 0);
    chk("to_next", 32'(grant), 32'b0010);
    mem_ready = 1'b1; mem_rdata = 32'h0000_C0DE;
    step();
    chk("zw_done", 32'(done), 32'b0010);
    chk("zw_rdata", rdata, 32'h0000_C0DE);
    mem_ready = 1'b0; req = 4'd0;
    step();

    // mem_ready in the watchdog's final cycle (ptr=2 -> winner 2)
    req = 4'b0100;
    step();
    chk("col_grant", 32'(grant), 32'b0100);
    for (int i = 0; i < 15; i++) step();
    mem_ready = 1'b1; mem_rdata = 32'h0BAD_F00D;
    step();
    chk("col_done", 32'(done), 32'b0100);
    chk("col_tmo", 32'(timeout), 0);
    chk("col_rdata", rdata, 32'h0BAD_F00D);
    mem_ready = 1'b0; req = 4'd0;
    step();

    // Request dropped mid-WAIT still completes (ptr=3 -> winner 0)
    req = 4'b0001;
    step();
    chk("drop_grant", 32'(grant), 32'b0001);
    req = 4'd0;
    step();
    step();
    chk("drop_held", 32'(grant), 32'b0001);
    mem_ready = 1'b1; mem_rdata = 32'h7777_0001;
    step();
    chk("drop_done", 32'(done), 32'b0001);
    chk("drop_rdata", rdata, 32'h7777_0001);
    mem_ready = 1'b0;
    step();
    chk("drop_idle", 32'(grant), 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter_4.md
Name: mem_port_arbiter_4

Overview:
- Round-robin arbiter and sequencer that shares one single-ported memory between four requesters.
- Drives the 2-bit select of the 32-bit 4-to-1 word mux that steers the requesters' address/write-data words onto the memory port.
- Issues one memory transaction per grant and returns the read word to the winner.
- Includes a watchdog that releases the port if the memory never answers.

Parameters:
- TIMEOUT, 16: maximum WAIT cycles per transaction before forced release (legal range 2..255).
- Data width is the project WORD_LENGTH macro (32); it is not a parameter.

Ports:
- clk  in  1  system clock, all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- req  in  4  per-requester request; the requester holds it high until its done or timeout pulse.
- mem_ready  in  1  memory completion strobe, one cycle.
- mem_rdata  in  WORD_LENGTH  memory read word, valid when mem_ready=1.
- sel  out  2  registered select for the 4-to-1 word mux; index of the current/last winner.
- grant  out  4  registered one-hot grant; all zero when idle.
- mem_start  out  1  one-cycle pulse launching the memory transaction.
- done  out  4  one-hot, one-cycle completion pulse to the winner.
- timeout  out  1  one-cycle pulse on watchdog release.
- rdata  out  WORD_LENGTH  read word latched on completion, held until the next completion.

Behaviour:
- Reset (asynchronous, immediate, including mid-transaction): state=IDLE, ptr=0, sel=0, grant=0, mem_start=0, done=0, timeout=0, rdata=0, wcnt=0.
- State IDLE:
  - If req!=0 at a posedge, the winner w is the first set bit of req scanning ptr, ptr+1, ... modulo 4.
  - Same edge: sel<=w, grant<=onehot(w), mem_start<=1, wcnt<=0, state<=WAIT.
  - mem_ready while in IDLE is ignored.
- State WAIT:
  - mem_start<=0 after its first cycle, so the pulse is exactly 1 cycle.
  - mem_ready is sampled every WAIT cycle, including the first; zero-wait memory is legal.
  - On mem_ready=1: rdata<=mem_rdata, done<=grant, grant<=0, ptr<=(w+1) mod 4, state<=IDLE.
  - Else if wcnt==TIMEOUT-1: timeout<=1, grant<=0, ptr<=(w+1) mod 4, state<=IDLE; done and rdata are unchanged.
  - Else wcnt<=wcnt+1.
  - mem_ready wins over timeout when both occur in the same cycle.
- done and timeout are single-cycle pulses, cleared on the next edge.
- sel holds its last value while idle so the mux output stays stable; it changes only at a grant edge.
- A req bit dropped during WAIT does not abort the transaction; completion proceeds normally.
- New req bits raised during WAIT are not considered until IDLE.
- Minimum spacing: at least one IDLE cycle between consecutive grants.
- Back-to-back single-requester throughput is one transaction per (memory latency + 2) cycles.
- Latency: req high at edge k → grant, sel and mem_start visible after edge k. mem_ready high at edge m → done and rdata visible after edge m.
- ptr wraps 3→0.
- Fairness: with all four requesting continuously, grant order is 0,1,2,3,0,...
- grant is always one-hot or zero. done is never asserted at the same time as grant.

Test Plan:
- Reset: rst=1 mid-WAIT with grant=0100 → all outputs 0 immediately; after release, req=0010 → sel=1, grant=0010.
- Single requester: req=1000, mem_ready 3 cycles after mem_start, mem_rdata=32'hDEADBEEF → mem_start 1 cycle, done=1000 for 1 cycle, rdata=DEADBEEF, sel stays 3.
- Round-robin: req=1111 held, memory answers after 1 cycle → grants 0001,0010,0100,1000,0001; one IDLE cycle between each.
- Skip: after a grant to 0, req=1001 → next grant is 3, then 0.
- Timeout: TIMEOUT=16, req=0001, no mem_ready → timeout pulse on the 16th WAIT cycle, done=0, rdata unchanged, next grant goes to the next requester.
- Edge cases:
  - mem_ready and timeout in the same cycle → done asserted, timeout=0.
  - Zero-wait memory (mem_ready in the mem_start cycle) → done on the next edge.
  - req dropped mid-WAIT → transaction still completes with done.
